commit_trace_emitter: RTL and testbench

//  Retire-side producer of the per-instruction commit trace. Sits after the WB stage of the pipelined proc,

---
 rtl/commit_trace_emitter_pkg.sv | 56 +++++
 rtl/commit_trace_emitter_if.sv | 32 +++
 rtl/commit_trace_emitter_fifo.sv | 47 ++++
 rtl/commit_trace_emitter.sv | 129 ++++++++++++
 tb/tb_commit_trace_emitter.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_emitter_pkg.sv
// Shared types for the retire-side commit trace emitter.
// Record classes, the buffered record layout, and the emitter FSM states.
package proc_trace_pkg;

    localparam int TR_CNT_W = 32;

    typedef enum logic [2:0] {
        BR   = 3'd0,
        REG  = 3'd1,
        LD   = 3'd2,
        ST   = 3'd3,
        STU  = 3'd4,
        HALT = 3'd5
    } trace_kind_e;

    // 'reg' is a keyword, so the destination index is reg_idx
    typedef struct packed {
        trace_kind_e         kind;
        logic [TR_CNT_W-1:0] inum;
        logic [TR_CNT_W-1:0] cycle;
        logic [15:0]         pc;
        logic [15:0]         inst;
        logic [2:0]          reg_idx;
        logic [15:0]         reg_data;
        logic [15:0]         mem_addr;
        logic [15:0]         mem_data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } trace_state_e;

    // Halt outranks everything; a register write paired with a store is STU
    function automatic trace_kind_e classify(
        input logic halt,
        input logic reg_wrt,
        input logic mem_read,
        input logic mem_write
    );
        if (halt)
            return HALT;
        else if (reg_wrt && mem_write)
            return STU;
        else if (reg_wrt && mem_read)
            return LD;
        else if (reg_wrt)
            return REG;
        else if (mem_write)
            return ST;
        else
            return BR;
    endfunction

endpackage

// File: rtl/commit_trace_emitter_if.sv
// Valid/ready trace record channel from the emitter to a trace consumer.
// The emitter drives the record fields; the consumer drives tr_ready.
interface commit_trace_emitter_if #(
    parameter int CNT_W = 32
);
    logic             tr_valid;
    logic             tr_ready;
    logic [2:0]       tr_kind;
    logic [CNT_W-1:0] tr_inum;
    logic [CNT_W-1:0] tr_cycle;
    logic [15:0]      tr_pc;
    logic [15:0]      tr_inst;
    logic [2:0]       tr_reg;
    logic [15:0]      tr_reg_data;
    logic [15:0]      tr_mem_addr;
    logic [15:0]      tr_mem_data;

    modport master (
        output tr_valid, tr_kind, tr_inum, tr_cycle,
        output tr_pc, tr_inst, tr_reg, tr_reg_data,
        output tr_mem_addr, tr_mem_data,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_kind, tr_inum, tr_cycle,
        input  tr_pc, tr_inst, tr_reg, tr_reg_data,
        input  tr_mem_addr, tr_mem_data,
        output tr_ready
    );

endinterface

// File: rtl/commit_trace_emitter_fifo.sv
// Synchronous FIFO of trace records with a registered head entry.
// A pushed record becomes visible one cycle later; no fall-through.
module trace_fifo
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  trace_rec_t wr_rec,
    output trace_rec_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t     mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wr_rec;
    end

    // Pointers carry an extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/commit_trace_emitter.sv
// Retire-side commit trace producer: classifies, stamps and buffers
// retiring instructions, back-pressures WB, and flags completion.
module commit_trace_emitter
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = TR_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    input  logic [15:0]            wb_pc,
    input  logic [15:0]            wb_inst,
    input  logic                   wb_reg_wrt,
    input  logic [2:0]             wb_target,
    input  logic [15:0]            wb_write_data,
    input  logic                   wb_mem_read,
    input  logic                   wb_mem_write,
    input  logic [15:0]            wb_mem_addr,
    input  logic [15:0]            wb_mem_data,
    input  logic                   wb_halt,
    output logic                   trace_stall,
    commit_trace_emitter_if.master tr,
    output logic [CNT_W-1:0]       inst_count,
    output logic [CNT_W-1:0]       cycle_count,
    output logic                   done,
    output logic                   overflow
);
    trace_state_e state;
    trace_state_e state_nxt;
    trace_rec_t   new_rec;
    trace_rec_t   head;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         running;

    assign running     = (state == RUN);
    assign tr.tr_valid = !empty && (state != HALTED);
    assign pop         = tr.tr_valid && tr.tr_ready;
    assign push        = wb_valid && running && (!full || pop);
    assign trace_stall = full && !pop;

    // Build the record; fields a class does not carry stay zero
    always_comb begin
        new_rec       = '0;
        new_rec.kind  = classify(wb_halt, wb_reg_wrt,
                                 wb_mem_read, wb_mem_write);
        new_rec.inum  = inst_count;
        new_rec.cycle = cycle_count;
        new_rec.pc    = wb_pc;
        new_rec.inst  = wb_inst;
        if (new_rec.kind inside {REG, LD, STU}) begin
            new_rec.reg_idx  = wb_target;
            new_rec.reg_data = wb_write_data;
        end
        if (new_rec.kind inside {LD, ST, STU})
            new_rec.mem_addr = wb_mem_addr;
        if (new_rec.kind inside {ST, STU})
            new_rec.mem_data = wb_mem_data;
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .wr_rec (new_rec),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    assign tr.tr_kind     = head.kind;
    assign tr.tr_inum     = head.inum;
    assign tr.tr_cycle    = head.cycle;
    assign tr.tr_pc       = head.pc;
    assign tr.tr_inst     = head.inst;
    assign tr.tr_reg      = head.reg_idx;
    assign tr.tr_reg_data = head.reg_data;
    assign tr.tr_mem_addr = head.mem_addr;
    assign tr.tr_mem_data = head.mem_data;

    // Counters and the sticky drop flag; the clock freezes once halted
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_count  <= '0;
            cycle_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (state != HALTED)
                cycle_count <= cycle_count + CNT_W'(1);
            if (push)
                inst_count <= inst_count + CNT_W'(1);
            if (wb_valid && running && full && !pop)
                overflow <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // FSM next state: stop accepting after HALT, finish when it drains
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        unique case (state)
            RUN:
                if (push && wb_halt)
                    state_nxt = DRAIN;
            DRAIN:
                if (pop && head.kind == HALT)
                    state_nxt = HALTED;
            HALTED:
                done = 1'b1;
            default:
                state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_commit_trace_emitter.sv
// Self-checking bench for commit_trace_emitter: directed scenarios
// plus randomized retire/consume traffic against a queue-based model.
module tb_commit_trace_emitter;
    import proc_trace_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wb_valid = 1'b0;
    logic [15:0]      wb_pc = '0;
    logic [15:0]      wb_inst = '0;
    logic             wb_reg_wrt = 1'b0;
    logic [2:0]       wb_target = '0;
    logic [15:0]      wb_write_data = '0;
    logic             wb_mem_read = 1'b0;
    logic             wb_mem_write = 1'b0;
    logic [15:0]      wb_mem_addr = '0;
    logic [15:0]      wb_mem_data = '0;
    logic             wb_halt = 1'b0;
    logic             trace_stall;
    logic [CNT_W-1:0] inst_count;
    logic [CNT_W-1:0] cycle_count;
    logic             done;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    commit_trace_emitter_if #(.CNT_W(CNT_W)) tr ();

    commit_trace_emitter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_pc         (wb_pc),
        .wb_inst       (wb_inst),
        .wb_reg_wrt    (wb_reg_wrt),
        .wb_target     (wb_target),
        .wb_write_data (wb_write_data),
        .wb_mem_read   (wb_mem_read),
        .wb_mem_write  (wb_mem_write),
        .wb_mem_addr   (wb_mem_addr),
        .wb_mem_data   (wb_mem_data),
        .wb_halt       (wb_halt),
        .trace_stall   (trace_stall),
        .tr            (tr),
        .inst_count    (inst_count),
        .cycle_count   (cycle_count),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of expected records plus plain counters
    trace_rec_t       exp_q[$];
    logic [CNT_W-1:0] m_inst = '0;
    logic [CNT_W-1:0] m_cyc = '0;
    bit               m_ovf = 1'b0;
    bit               m_drain = 1'b0;
    bit               m_done = 1'b0;

    function automatic trace_rec_t mk(
        input trace_kind_e k, input int unsigned n, input int unsigned c,
        input logic [15:0] pc, input logic [15:0] inst,
        input logic [2:0] rg, input logic [15:0] rd,
        input logic [15:0] ma, input logic [15:0] md
    );
        trace_rec_t r;
        r.kind = k;
        r.inum = n;
        r.cycle = c;
        r.pc = pc;
        r.inst = inst;
        r.reg_idx = rg;
        r.reg_data = rd;
        r.mem_addr = ma;
        r.mem_data = md;
        return r;
    endfunction

    function automatic trace_rec_t expect_rec();
        trace_kind_e k;
        bit has_reg, has_addr, has_data;
        if (wb_halt) k = HALT;
        else if (wb_reg_wrt && wb_mem_write) k = STU;
        else if (wb_reg_wrt && wb_mem_read) k = LD;
        else if (wb_reg_wrt) k = REG;
        else if (wb_mem_write) k = ST;
        else k = BR;
        has_reg = (k == REG) || (k == LD) || (k == STU);
        has_addr = (k == LD) || (k == ST) || (k == STU);
        has_data = (k == ST) || (k == STU);
        return mk(k, m_inst, m_cyc, wb_pc, wb_inst,
                  has_reg ? wb_target : 3'd0,
                  has_reg ? wb_write_data : 16'd0,
                  has_addr ? wb_mem_addr : 16'd0,
                  has_data ? wb_mem_data : 16'd0);
    endfunction

    function automatic trace_rec_t dut_rec();
        trace_rec_t r;
        r.kind = trace_kind_e'(tr.tr_kind);
        r.inum = tr.tr_inum;
        r.cycle = tr.tr_cycle;
        r.pc = tr.tr_pc;
        r.inst = tr.tr_inst;
        r.reg_idx = tr.tr_reg;
        r.reg_data = tr.tr_reg_data;
        r.mem_addr = tr.tr_mem_addr;
        r.mem_data = tr.tr_mem_data;
        return r;
    endfunction

    // One clock: model evaluates the edge from the current inputs
    task automatic tick();
        bit full_now, pop_now, push_now, live;
        trace_rec_t rec;
        live = !m_drain && !m_done;
        full_now = (exp_q.size() == DEPTH);
        pop_now = (exp_q.size() != 0) && tr.tr_ready;
        push_now = wb_valid && live && (!full_now || pop_now);
        rec = expect_rec();
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_inst = '0;
            m_cyc = '0;
            m_ovf = 1'b0;
            m_drain = 1'b0;
            m_done = 1'b0;
        end else begin
            if (!m_done) m_cyc++;
            if (pop_now) begin
                if (exp_q[0].kind == HALT) begin
                    m_done = 1'b1;
                    m_drain = 1'b0;
                end
                void'(exp_q.pop_front());
            end
            if (push_now) begin
                exp_q.push_back(rec);
                m_inst++;
                if (rec.kind == HALT) m_drain = 1'b1;
            end else if (wb_valid && live && full_now) begin
                m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic retire(
        input bit h, input bit rw, input bit mr, input bit mw,
        input logic [15:0] pc, input logic [15:0] inst,
        input logic [2:0] tgt, input logic [15:0] wd,
        input logic [15:0] ma, input logic [15:0] md
    );
        wb_valid = 1'b1;
        wb_halt = h;
        wb_reg_wrt = rw;
        wb_mem_read = mr;
        wb_mem_write = mw;
        wb_pc = pc;
        wb_inst = inst;
        wb_target = tgt;
        wb_write_data = wd;
        wb_mem_addr = ma;
        wb_mem_data = md;
    endtask

    task automatic idle();
        wb_valid = 1'b0;
        wb_halt = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        tr.tr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({tr.tr_valid, trace_stall, done, overflow} !== 4'b0) begin
            errors++;
            $display("FAIL reset flags: got v/stall/done/ovf=%b want 0000",
                     {tr.tr_valid, trace_stall, done, overflow});
        end
        checks++;
        if (inst_count !== '0 || cycle_count !== '0) begin
            errors++;
            $display("FAIL reset counters: got inst=%0d cyc=%0d want 0 0",
                     inst_count, cycle_count);
        end
        checks++;
        if (dut_rec() !== '0) begin
            errors++;
            $display("FAIL reset record: got %h want 0", dut_rec());
        end
        tick();
    endtask

    task automatic test_basic();
        trace_rec_t exp;
        apply_reset();
        tr.tr_ready = 1'b1;
        retire(0, 1, 0, 0, 16'h0000, 16'h5305, 3'd3, 16'h0005,
               16'h0005, 16'hAAAA);
        @(negedge clk);
        tick();
        idle();
        @(negedge clk);
        exp = mk(REG, 0, 0, 16'h0000, 16'h5305, 3'd3, 16'h0005, 0, 0);
        checks++;
        if (tr.tr_valid !== 1'b1 || dut_rec() !== exp) begin
            errors++;
            $display("FAIL basic REG: got v=%b %h want v=1 %h",
                     tr.tr_valid, dut_rec(), exp);
        end
        tick();
        @(negedge clk);
        checks++;
        if (tr.tr_valid !== 1'b0 || inst_count !== 32'd1) begin
            errors++;
            $display("FAIL basic drain: got v=%b inst=%0d want v=0 inst=1",
                     tr.tr_valid, inst_count);
        end
    endtask

    task automatic test_classify();
        trace_rec_t exp;
        apply_reset();
        tr.tr_ready = 1'b1;
        retire(0, 1, 1, 0, 16'h0002, 16'h4A10, 3'd1, 16'h1234,
               16'h0010, 16'h7777);
        @(negedge clk);
        tick();
        retire(0, 0, 0, 1, 16'h0004, 16'h6B20, 3'd5, 16'h5555,
               16'h0020, 16'hBEEF);
        @(negedge clk);
        exp = mk(LD, 0, 0, 16'h0002, 16'h4A10, 3'd1, 16'h1234,
                 16'h0010, 16'h0000);
        checks++;
        if (dut_rec() !== exp) begin
            errors++;
            $display("FAIL classify LD: got %h want %h", dut_rec(), exp);
        end
        tick();
        retire(0, 1, 0, 1, 16'h0006, 16'h6E30, 3'd2, 16'h0022,
               16'h0030, 16'hCAFE);
        @(negedge clk);
        exp = mk(ST, 1, 1, 16'h0004, 16'h6B20, 3'd0, 16'h0000,
                 16'h0020, 16'hBEEF);
        checks++;
        if (dut_rec() !== exp) begin
            errors++;
            $display("FAIL classify ST: got %h want %h", dut_rec(), exp);
        end
        tick();
        idle();
        @(negedge clk);
        exp = mk(STU, 2, 2, 16'h0006, 16'h6E30, 3'd2, 16'h0022,
                 16'h0030, 16'hCAFE);
        checks++;
        if (dut_rec() !== exp) begin
            errors++;
            $display("FAIL classify STU: got %h want %h", dut_rec(), exp);
        end
        tick();
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            retire(0, 1, 0, 0, 16'(i * 2), 16'h1000, 3'd4, 16'(i),
                   16'h0, 16'h0);
            @(negedge clk);
            checks++;
            if (trace_stall !== 1'b0) begin
                errors++;
                $display("FAIL overflow early stall %0d: got %b want 0",
                         i, trace_stall);
            end
            tick();
        end
        retire(0, 1, 0, 0, 16'h0008, 16'h1000, 3'd4, 16'h0004,
               16'h0, 16'h0);
        @(negedge clk);
        checks++;
        if (trace_stall !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow full: got stall=%b ovf=%b want 1 0",
                     trace_stall, overflow);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || inst_count !== 32'd4) begin
            errors++;
            $display("FAIL overflow drop: got ovf=%b inst=%0d want 1 4",
                     overflow, inst_count);
        end
        checks++;
        if (tr.tr_valid !== 1'b1 || tr.tr_inum !== 32'd0) begin
            errors++;
            $display("FAIL overflow head: got v=%b inum=%0d want 1 0",
                     tr.tr_valid, tr.tr_inum);
        end
        tick();
    endtask

    task automatic test_full_pop();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            retire(0, 0, 0, 0, 16'(i * 2), 16'h0F00, 3'd0, 16'h0,
                   16'h0, 16'h0);
            @(negedge clk);
            tick();
        end
        retire(0, 0, 0, 0, 16'h0008, 16'h0F00, 3'd0, 16'h0, 16'h0, 16'h0);
        tr.tr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (trace_stall !== 1'b0 || tr.tr_inum !== 32'd0) begin
            errors++;
            $display("FAIL full_pop stall: got stall=%b inum=%0d want 0 0",
                     trace_stall, tr.tr_inum);
        end
        tick();
        idle();
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            checks++;
            if (tr.tr_valid !== 1'b1 || tr.tr_inum !== 32'(k) ||
                tr.tr_pc !== 16'(k * 2)) begin
                errors++;
                $display("FAIL full_pop order %0d: got v=%b inum=%0d pc=%h",
                         k, tr.tr_valid, tr.tr_inum, tr.tr_pc);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (tr.tr_valid !== 1'b0 || overflow !== 1'b0 ||
            inst_count !== 32'd5) begin
            errors++;
            $display("FAIL full_pop end: got v=%b ovf=%b inst=%0d want 0 0 5",
                     tr.tr_valid, overflow, inst_count);
        end
    endtask

    task automatic test_random();
        trace_rec_t exp_head;
        bit exp_stall;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 7)
                retire(0, 1'($urandom), 1'($urandom), 1'($urandom),
                       16'($urandom), 16'($urandom), 3'($urandom),
                       16'($urandom), 16'($urandom), 16'($urandom));
            else
                idle();
            tr.tr_ready = ($urandom_range(0, 9) < 4);
            @(negedge clk);
            exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
            exp_stall = (exp_q.size() == DEPTH) && !tr.tr_ready;
            checks++;
            if (tr.tr_valid !== (exp_q.size() != 0) ||
                (exp_q.size() != 0 && dut_rec() !== exp_head)) begin
                errors++;
                $display("FAIL random head @%0d: got v=%b %h want %h",
                         n, tr.tr_valid, dut_rec(), exp_head);
            end
            checks++;
            if (trace_stall !== exp_stall || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random flags @%0d: got stall=%b ovf=%b want %b %b",
                         n, trace_stall, overflow, exp_stall, m_ovf);
            end
            checks++;
            if (inst_count !== m_inst || cycle_count !== m_cyc) begin
                errors++;
                $display("FAIL random counts @%0d: got %0d/%0d want %0d/%0d",
                         n, inst_count, cycle_count, m_inst, m_cyc);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_halt();
        trace_rec_t exp;
        apply_reset();
        tr.tr_ready = 1'b1;
        retire(0, 0, 0, 0, 16'h0010, 16'hC000, 3'd7, 16'h1111,
               16'h2222, 16'h3333);
        @(negedge clk);
        tick();
        retire(1, 1, 0, 1, 16'h0012, 16'hF000, 3'd6, 16'h4444,
               16'h5555, 16'h6666);
        @(negedge clk);
        exp = mk(BR, 0, 0, 16'h0010, 16'hC000, 0, 0, 0, 0);
        checks++;
        if (dut_rec() !== exp) begin
            errors++;
            $display("FAIL halt BR: got %h want %h", dut_rec(), exp);
        end
        tick();
        retire(0, 1, 0, 0, 16'h0014, 16'h1234, 3'd1, 16'h0001,
               16'h0, 16'h0);
        @(negedge clk);
        exp = mk(HALT, 1, 1, 16'h0012, 16'hF000, 0, 0, 0, 0);
        checks++;
        if (dut_rec() !== exp || done !== 1'b0) begin
            errors++;
            $display("FAIL halt rec: got done=%b %h want done=0 %h",
                     done, dut_rec(), exp);
        end
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || tr.tr_valid !== 1'b0 ||
            cycle_count !== 32'd3 || inst_count !== 32'd2) begin
            errors++;
            $display("FAIL halt done: got done=%b v=%b cyc=%0d inst=%0d",
                     done, tr.tr_valid, cycle_count, inst_count);
        end
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cycle_count !== m_cyc ||
            cycle_count !== 32'd3 || inst_count !== 32'd2 ||
            overflow !== 1'b0 || trace_stall !== 1'b0) begin
            errors++;
            $display("FAIL halt frozen: got done=%b cyc=%0d inst=%0d ovf=%b",
                     done, cycle_count, inst_count, overflow);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            retire(0, 1, 0, 0, 16'(i), 16'h2000, 3'd2, 16'(i),
                   16'h0, 16'h0);
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        checks++;
        if (tr.tr_valid !== 1'b1 || inst_count !== 32'd3) begin
            errors++;
            $display("FAIL reset_mid pre: got v=%b inst=%0d want 1 3",
                     tr.tr_valid, inst_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (tr.tr_valid !== 1'b0 || inst_count !== '0 ||
            cycle_count !== '0 || overflow !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid post: got v=%b inst=%0d cyc=%0d ovf=%b",
                     tr.tr_valid, inst_count, cycle_count, overflow);
        end
        retire(0, 0, 0, 1, 16'h0040, 16'h7000, 3'd0, 16'h0,
               16'h0044, 16'h0048);
        @(negedge clk);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (tr.tr_valid !== 1'b1 || tr.tr_inum !== 32'd0 ||
            tr.tr_kind !== 3'(ST) || tr.tr_pc !== 16'h0040) begin
            errors++;
            $display("FAIL reset_mid run: got v=%b inum=%0d kind=%0d pc=%h",
                     tr.tr_valid, tr.tr_inum, tr.tr_kind, tr.tr_pc);
        end
        tick();
    endtask

    initial begin
        tr.tr_ready = 1'b0;
        test_reset();
        test_basic();
        test_classify();
        test_overflow();
        test_full_pop();
        test_random();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
